apb_initiator: RTL and testbench

- Single-outstanding APB3/APB4 requester bridge.
- Converts a valid/ready request/response interface from the CPU-side crossbar into APB transfers.
- Drives APB responders such as the GPIO, UART and SPI peripheral blocks.
- One transfer in flight; SETUP and ACCESS phases per the APB protocol; wait states are honoured.

---
 rtl/apb_initiator_if.sv | 46 ++++
 rtl/apb_initiator.sv | 129 ++++++++++++
 tb/tb_apb_initiator.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_initiator_if.sv
// Request/response and APB bus bundle for apb_initiator.
// master: the bridge itself; slave: the upstream requester plus APB responder side.
interface apb_initiator_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic [2:0]        req_prot;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] out_paddr;
  logic              out_psel;
  logic              out_penable;
  logic [2:0]        out_pprot;
  logic              out_pwrite;
  logic [DATA_W-1:0] out_pwdata;
  logic [STRB_W-1:0] out_pstrb;
  logic              out_pready;
  logic [DATA_W-1:0] out_prdata;
  logic              out_pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, req_prot,
    input  resp_ready, out_pready, out_prdata, out_pslverr,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, req_prot,
    output resp_ready, out_pready, out_prdata, out_pslverr,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb
  );
endinterface

// File: rtl/apb_initiator.sv
// Single-outstanding valid/ready to APB3/APB4 requester bridge.
// Optional ACCESS-phase timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_initiator #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic             clock,
  input logic             reset,
  apb_initiator_if.master bus
);
  localparam int unsigned STRB_W = DATA_W / 8;

  if (DATA_W == 0 || (DATA_W % 8) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("apb_initiator: DATA_W must be a nonzero multiple of 8 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              psel_q;
  logic              penable_q;
  logic [2:0]        pprot_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(32'hDEADBEEF);
  logic [CNT_W-1:0] wait_cnt_q;
`endif

  // Transfer sequencer; all bus-facing outputs come straight from these flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      paddr_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pprot_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            paddr_q  <= bus.req_addr;
            pwrite_q <= bus.req_write;
            pprot_q  <= bus.req_prot;
            // Reads carry no data and no strobes on the bus.
            pwdata_q <= bus.req_write ? bus.req_wdata : '0;
            pstrb_q  <= bus.req_write ? bus.req_wstrb : '0;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (bus.out_pready) begin
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= pwrite_q ? '0 : bus.out_prdata;
            resp_err_q   <= bus.out_pslverr;
            state_q      <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          // A ready responder on the limit cycle still wins over the abort.
          else if (wait_cnt_q == CNT_LAST) begin
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= TMO_DATA;
            resp_err_q   <= 1'b1;
            wait_cnt_q   <= wait_cnt_q + CNT_W'(1);
            state_q      <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accept only from IDLE; decoded from the state flop, independent of resp_ready.
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.out_paddr   = paddr_q;
  assign bus.out_psel    = psel_q;
  assign bus.out_penable = penable_q;
  assign bus.out_pprot   = pprot_q;
  assign bus.out_pwrite  = pwrite_q;
  assign bus.out_pwdata  = pwdata_q;
  assign bus.out_pstrb   = pstrb_q;
endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator: directed scenarios plus randomized
// transfers compared against a transaction-level expectation model.
module tb_apb_initiator;
`ifdef APB_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 1024;
`endif

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  apb_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] prdata;
    logic        pslverr;
    int          resp_delay;
    logic        hold_valid;
  } xfer_t;

  typedef struct {
    int          psel_cyc, pen_cyc, resp_cyc;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pwrite;
    logic [2:0]  pprot;
    logic [31:0] rdata;
    logic        err;
    int          stable_err, ready_err, hold_err;
    logic        ready_after, psel_after, valid_after, timed_out;
  } obs_t;

  typedef struct {
    int          resp_cyc;
    logic [31:0] pwdata, rdata;
    logic [3:0]  pstrb;
    logic        err;
  } exp_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected outcome of one transfer, from the protocol rules only.
  function automatic exp_t model(input xfer_t t);
    exp_t e;
    e.pstrb  = t.write ? t.wstrb : 4'h0;
    e.pwdata = t.write ? t.wdata : 32'h0;
    e.resp_cyc = 3 + t.waits;
    e.rdata  = t.write ? 32'h0 : t.prdata;
    e.err    = t.pslverr;
`ifdef APB_TIMEOUT_EN
    if (t.waits >= int'(TMO)) begin
      e.resp_cyc = 2 + int'(TMO);
      e.rdata    = 32'hDEADBEEF;
      e.err      = 1'b1;
    end
`endif
    return e;
  endfunction

  // Drives one request, plays the APB responder, records what the DUT did.
  task automatic do_xfer(input xfer_t t, output obs_t o);
    int cyc, acc, budget;
    o.psel_cyc = -1; o.pen_cyc = -1; o.resp_cyc = -1;
    o.paddr = '0; o.pwdata = '0; o.pstrb = '0; o.pwrite = 1'b0; o.pprot = '0;
    o.rdata = '0; o.err = 1'b0;
    o.stable_err = 0; o.ready_err = 0; o.hold_err = 0;
    o.ready_after = 1'b0; o.psel_after = 1'b1; o.valid_after = 1'b1; o.timed_out = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = t.write; bus.req_addr = t.addr;
    bus.req_wdata = t.wdata; bus.req_wstrb = t.wstrb; bus.req_prot = t.prot;
    budget = 0;
    while (bus.req_ready !== 1'b1 && budget < 50) begin step(); budget++; end
    if (budget >= 50) begin o.timed_out = 1'b1; bus.req_valid = 1'b0; return; end
    cyc = 0; acc = 0;
    while (1) begin
      step(); cyc++;
      if (!t.hold_valid) bus.req_valid = 1'b0;
      if (bus.req_ready !== 1'b0) o.ready_err++;
      if (bus.resp_valid === 1'b1) begin
        o.resp_cyc = cyc; o.rdata = bus.resp_rdata; o.err = bus.resp_err;
        bus.out_pready = 1'b0;
        if (bus.out_psel !== 1'b0) o.ready_err++;
        for (int d = 0; d < t.resp_delay; d++) begin
          bus.resp_ready = 1'b0; step();
          if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== o.rdata || bus.resp_err !== o.err) o.hold_err++;
          if (bus.req_ready !== 1'b0 || bus.out_psel !== 1'b0) o.ready_err++;
        end
        bus.resp_ready = 1'b1; step(); bus.resp_ready = 1'b0;
        o.ready_after = bus.req_ready; o.psel_after = bus.out_psel; o.valid_after = bus.resp_valid;
        break;
      end
      if (bus.out_psel === 1'b1) begin
        if (o.psel_cyc < 0) begin
          o.psel_cyc = cyc; o.paddr = bus.out_paddr; o.pwdata = bus.out_pwdata;
          o.pstrb = bus.out_pstrb; o.pwrite = bus.out_pwrite; o.pprot = bus.out_pprot;
        end else if (bus.out_paddr !== o.paddr || bus.out_pwdata !== o.pwdata || bus.out_pstrb !== o.pstrb ||
                     bus.out_pwrite !== o.pwrite || bus.out_pprot !== o.pprot) begin
          o.stable_err++;
        end
      end
      if (bus.out_psel === 1'b1 && bus.out_penable === 1'b1) begin
        acc++;
        if (o.pen_cyc < 0) o.pen_cyc = cyc;
        if (acc == t.waits + 1) begin
          bus.out_pready = 1'b1; bus.out_prdata = t.prdata; bus.out_pslverr = t.pslverr;
        end else begin
          bus.out_pready = 1'b0; bus.out_prdata = $urandom; bus.out_pslverr = 1'($urandom);
        end
      end else begin
        bus.out_pready = 1'($urandom); bus.out_prdata = $urandom; bus.out_pslverr = 1'($urandom);
      end
      if (cyc > 200) begin o.timed_out = 1'b1; break; end
    end
    bus.out_pready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if (bus.out_psel !== 1'b0 || bus.out_penable !== 1'b0 || bus.out_paddr !== 32'h0 ||
        bus.out_pwdata !== 32'h0 || bus.out_pstrb !== 4'h0 || bus.out_pwrite !== 1'b0 || bus.out_pprot !== 3'h0) begin
      errors++;
      $display("FAIL reset_apb: got psel=%b pen=%b paddr=%h pwdata=%h pstrb=%h pwrite=%b pprot=%h want all 0",
               bus.out_psel, bus.out_penable, bus.out_paddr, bus.out_pwdata, bus.out_pstrb, bus.out_pwrite, bus.out_pprot);
    end
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: got valid=%b rdata=%h err=%b want 0/0/0", bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_write();
    xfer_t t; obs_t o;
    t = '{write:1'b1, addr:32'h10002000, wdata:32'h0000A5A5, wstrb:4'h3, prot:3'h2, waits:0,
          prdata:32'h77777777, pslverr:1'b0, resp_delay:0, hold_valid:1'b0};
    do_xfer(t, o);
    checks++; if (o.timed_out) begin errors++; $display("FAIL write_bound: got timeout want completion"); end
    checks++; if (o.psel_cyc !== 1 || o.pen_cyc !== 2) begin errors++; $display("FAIL write_phase: got psel@%0d pen@%0d want 1/2", o.psel_cyc, o.pen_cyc); end
    checks++; if (o.resp_cyc !== 3) begin errors++; $display("FAIL write_latency: got %0d want 3", o.resp_cyc); end
    checks++; if (o.pstrb !== 4'h3 || o.pwdata !== 32'h0000A5A5 || o.pwrite !== 1'b1 || o.pprot !== 3'h2 || o.paddr !== 32'h10002000) begin
      errors++; $display("FAIL write_bus: got paddr=%h pwdata=%h pstrb=%h pwrite=%b pprot=%h", o.paddr, o.pwdata, o.pstrb, o.pwrite, o.pprot); end
    checks++; if (o.rdata !== 32'h0 || o.err !== 1'b0) begin errors++; $display("FAIL write_resp: got rdata=%h err=%b want 0/0", o.rdata, o.err); end
  endtask

  task automatic test_read_wait();
    xfer_t t; obs_t o;
    t = '{write:1'b0, addr:32'h10002000, wdata:32'hFFFFFFFF, wstrb:4'hF, prot:3'h0, waits:3,
          prdata:32'h00001234, pslverr:1'b0, resp_delay:0, hold_valid:1'b0};
    do_xfer(t, o);
    checks++; if (o.pstrb !== 4'h0 || o.pwdata !== 32'h0 || o.pwrite !== 1'b0) begin
      errors++; $display("FAIL read_bus: got pstrb=%h pwdata=%h pwrite=%b want 0/0/0", o.pstrb, o.pwdata, o.pwrite); end
    checks++; if (o.stable_err !== 0) begin errors++; $display("FAIL read_stable: got %0d unstable cycles want 0", o.stable_err); end
    checks++; if (o.resp_cyc !== 6) begin errors++; $display("FAIL read_latency: got %0d want 6", o.resp_cyc); end
    checks++; if (o.rdata !== 32'h00001234 || o.err !== 1'b0) begin errors++; $display("FAIL read_resp: got rdata=%h err=%b want 00001234/0", o.rdata, o.err); end
  endtask

  task automatic test_slverr();
    xfer_t t; obs_t o;
    t = '{write:1'b0, addr:32'h40000010, wdata:32'h0, wstrb:4'h0, prot:3'h5, waits:1,
          prdata:32'hCAFE0001, pslverr:1'b1, resp_delay:1, hold_valid:1'b0};
    do_xfer(t, o);
    checks++; if (o.err !== 1'b1 || o.rdata !== 32'hCAFE0001) begin errors++; $display("FAIL slverr_resp: got rdata=%h err=%b want cafe0001/1", o.rdata, o.err); end
    checks++; if (o.ready_after !== 1'b1 || o.valid_after !== 1'b0) begin errors++; $display("FAIL slverr_idle: got ready=%b valid=%b want 1/0", o.ready_after, o.valid_after); end
  endtask

  task automatic test_back_to_back();
    xfer_t t; obs_t o;
    t = '{write:1'b1, addr:32'h20000004, wdata:32'h12345678, wstrb:4'hC, prot:3'h1, waits:0,
          prdata:32'h0, pslverr:1'b0, resp_delay:5, hold_valid:1'b1};
    do_xfer(t, o);
    checks++; if (o.hold_err !== 0) begin errors++; $display("FAIL b2b_hold: got %0d unstable resp cycles want 0", o.hold_err); end
    checks++; if (o.ready_err !== 0) begin errors++; $display("FAIL b2b_req_ready: got %0d busy cycles with req_ready/psel high want 0", o.ready_err); end
    checks++; if (o.ready_after !== 1'b1 || o.psel_after !== 1'b0) begin errors++; $display("FAIL b2b_gap: got ready=%b psel=%b want 1/0", o.ready_after, o.psel_after); end
    t = '{write:1'b0, addr:32'h20000008, wdata:32'h0, wstrb:4'h0, prot:3'h0, waits:0,
          prdata:32'h0BADF00D, pslverr:1'b0, resp_delay:0, hold_valid:1'b0};
    do_xfer(t, o);
    checks++; if (o.psel_cyc !== 1 || o.paddr !== 32'h20000008 || o.rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL b2b_second: got psel@%0d paddr=%h rdata=%h want 1/20000008/0badf00d", o.psel_cyc, o.paddr, o.rdata); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h30000000;
    bus.req_wdata = 32'h55AA55AA; bus.req_wstrb = 4'hF; bus.req_prot = 3'h3; bus.out_pready = 1'b0;
    step(); bus.req_valid = 1'b0;
    step(); step();
    checks++; if (bus.out_penable !== 1'b1) begin errors++; $display("FAIL mid_pre_access: got penable=%b want 1", bus.out_penable); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_psel !== 1'b0 || bus.out_penable !== 1'b0 || bus.resp_valid !== 1'b0 || bus.out_paddr !== 32'h0) begin
      errors++; $display("FAIL mid_async_clear: got psel=%b pen=%b valid=%b paddr=%h want 0", bus.out_psel, bus.out_penable, bus.resp_valid, bus.out_paddr);
    end
    #1 reset = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_req_ready: got %b want 1", bus.req_ready); end
    bad = 0; bus.resp_ready = 1'b1; bus.out_pready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.resp_valid !== 1'b0 || bus.out_psel !== 1'b0) bad++;
    end
    bus.resp_ready = 1'b0; bus.out_pready = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_no_resp: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_random();
    xfer_t t; obs_t o; exp_t e;
    for (int i = 0; i < 24; i++) begin
      t.write = 1'($urandom); t.addr = $urandom; t.wdata = $urandom; t.wstrb = 4'($urandom);
      t.prot = 3'($urandom); t.waits = int'($urandom_range(0, 4)); t.prdata = $urandom;
      t.pslverr = ($urandom_range(0, 3) == 0); t.resp_delay = int'($urandom_range(0, 3)); t.hold_valid = 1'b0;
      e = model(t);
      do_xfer(t, o);
      checks++; if (o.timed_out) begin errors++; $display("FAIL rand[%0d] bound: got timeout want completion", i); end
      checks++; if (o.psel_cyc !== 1 || o.pen_cyc !== 2 || o.resp_cyc !== e.resp_cyc) begin
        errors++; $display("FAIL rand[%0d] timing: got %0d/%0d/%0d want 1/2/%0d", i, o.psel_cyc, o.pen_cyc, o.resp_cyc, e.resp_cyc); end
      checks++; if (o.paddr !== t.addr || o.pwrite !== t.write || o.pprot !== t.prot || o.pwdata !== e.pwdata || o.pstrb !== e.pstrb) begin
        errors++; $display("FAIL rand[%0d] bus: got %h %b %h %h %h want %h %b %h %h %h", i, o.paddr, o.pwrite, o.pprot, o.pwdata, o.pstrb,
                           t.addr, t.write, t.prot, e.pwdata, e.pstrb); end
      checks++; if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL rand[%0d] resp: got %h/%b want %h/%b", i, o.rdata, o.err, e.rdata, e.err); end
      checks++; if (o.stable_err !== 0 || o.hold_err !== 0 || o.ready_err !== 0) begin
        errors++; $display("FAIL rand[%0d] protocol: got stable=%0d hold=%0d ready=%0d want 0/0/0", i, o.stable_err, o.hold_err, o.ready_err); end
      checks++; if (o.ready_after !== 1'b1 || o.valid_after !== 1'b0 || o.psel_after !== 1'b0) begin
        errors++; $display("FAIL rand[%0d] idle: got ready=%b valid=%b psel=%b want 1/0/0", i, o.ready_after, o.valid_after, o.psel_after); end
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    xfer_t t; obs_t o; exp_t e;
    t = '{write:1'b0, addr:32'h50000000, wdata:32'h0, wstrb:4'h0, prot:3'h0, waits:1000,
          prdata:32'h11111111, pslverr:1'b0, resp_delay:0, hold_valid:1'b0};
    e = model(t);
    do_xfer(t, o);
    checks++; if (o.resp_cyc !== e.resp_cyc || o.err !== 1'b1 || o.rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL timeout_abort: got cyc=%0d err=%b rdata=%h want %0d/1/deadbeef", o.resp_cyc, o.err, o.rdata, e.resp_cyc); end
    t.waits = int'(TMO) - 1;
    e = model(t);
    do_xfer(t, o);
    checks++; if (o.resp_cyc !== e.resp_cyc || o.err !== 1'b0 || o.rdata !== 32'h11111111) begin
      errors++; $display("FAIL timeout_pready_wins: got cyc=%0d err=%b rdata=%h want %0d/0/11111111", o.resp_cyc, o.err, o.rdata, e.resp_cyc); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_wstrb = '0; bus.req_prot = '0; bus.resp_ready = 1'b0;
    bus.out_pready = 1'b0; bus.out_prdata = '0; bus.out_pslverr = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
